// File: rtl/gate_arbiter.sv
// Four-way round-robin arbiter that shares one single-bit logic unit.
// Each grant runs GRANT -> EXEC -> RELEASE; an over-long hold is force-released and flagged.
module gate_arbiter #(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [7:0] opcode,
    input  logic [3:0] opnd_a,
    input  logic [3:0] opnd_b,
    input  logic [3:0] opnd_s,
    output logic [3:0] gnt,
    output logic       result,
    output logic       valid,
    output logic [1:0] owner,
    output logic       busy,
    output logic       hold_err
);

    localparam int unsigned NREQ   = 4;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned HOLD_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_EXEC    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t              r_state,    w_state_nxt;
    logic [IDX_W-1:0]    r_ptr,      w_ptr_nxt;
    logic [IDX_W-1:0]    r_win,      w_win_nxt;
    logic [1:0]          r_op,       w_op_nxt;
    logic                r_a,        w_a_nxt;
    logic                r_b,        w_b_nxt;
    logic                r_s,        w_s_nxt;
    logic [HOLD_W-1:0]   r_hold_cnt, w_hold_cnt_nxt;
    logic [NREQ-1:0]     r_gnt,      w_gnt_nxt;
    logic                r_result,   w_result_nxt;
    logic                r_valid,    w_valid_nxt;
    logic [IDX_W-1:0]    r_owner,    w_owner_nxt;
    logic                r_busy,     w_busy_nxt;
    logic                r_hold_err, w_hold_err_nxt;

    logic [IDX_W-1:0]    w_pick;
    logic                w_req_win;

    // First requester at or after the pointer, wrapping mod 4.
    function automatic logic [IDX_W-1:0] f_pick(input logic [NREQ-1:0] r,
                                                 input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] idx;
        f_pick = p;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = p + IDX_W'(i);
            if (r[idx]) f_pick = idx;
        end
    endfunction

    function automatic logic f_alu(input logic [1:0] op, input logic a,
                                   input logic b, input logic s);
        case (op)
            2'b00:   f_alu = ~a;
            2'b01:   f_alu = a | b;
            2'b10:   f_alu = s ? b : a;
            default: f_alu = a;
        endcase
    endfunction

    assign w_pick    = f_pick(req, r_ptr);
    assign w_req_win = req[r_win];

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_win      <= '0;
            r_op       <= '0;
            r_a        <= 1'b0;
            r_b        <= 1'b0;
            r_s        <= 1'b0;
            r_hold_cnt <= '0;
            r_gnt      <= '0;
            r_result   <= 1'b0;
            r_valid    <= 1'b0;
            r_owner    <= '0;
            r_busy     <= 1'b0;
            r_hold_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_win      <= w_win_nxt;
            r_op       <= w_op_nxt;
            r_a        <= w_a_nxt;
            r_b        <= w_b_nxt;
            r_s        <= w_s_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_gnt      <= w_gnt_nxt;
            r_result   <= w_result_nxt;
            r_valid    <= w_valid_nxt;
            r_owner    <= w_owner_nxt;
            r_busy     <= w_busy_nxt;
            r_hold_err <= w_hold_err_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_win_nxt      = r_win;
        w_op_nxt       = r_op;
        w_a_nxt        = r_a;
        w_b_nxt        = r_b;
        w_s_nxt        = r_s;
        w_hold_cnt_nxt = r_hold_cnt;
        w_gnt_nxt      = r_gnt;
        w_result_nxt   = r_result;
        w_valid_nxt    = 1'b0;
        w_owner_nxt    = r_owner;
        w_hold_err_nxt = r_hold_err;

        case (r_state)
            ST_IDLE: begin
                w_hold_cnt_nxt = '0;
                if (|req) begin
                    w_win_nxt   = w_pick;
                    w_gnt_nxt   = NREQ'(1) << w_pick;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!w_req_win) begin
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = r_win + IDX_W'(1);
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_op_nxt    = opcode[{r_win, 1'b0} +: 2];
                    w_a_nxt     = opnd_a[r_win];
                    w_b_nxt     = opnd_b[r_win];
                    w_s_nxt     = opnd_s[r_win];
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_result_nxt   = f_alu(r_op, r_a, r_b, r_s);
                w_valid_nxt    = 1'b1;
                w_owner_nxt    = r_win;
                w_hold_cnt_nxt = '0;
                w_state_nxt    = ST_RELEASE;
            end
            ST_RELEASE: begin
                // A hold reaching HOLD_MAX is released exactly like a dropped request, plus the sticky flag.
                if (!w_req_win || (r_hold_cnt == HOLD_W'(HOLD_MAX - 1))) begin
                    w_gnt_nxt      = '0;
                    w_ptr_nxt      = r_win + IDX_W'(1);
                    w_hold_cnt_nxt = '0;
                    w_state_nxt    = ST_IDLE;
                    if (w_req_win) w_hold_err_nxt = 1'b1;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    assign gnt      = r_gnt;
    assign result   = r_result;
    assign valid    = r_valid;
    assign owner    = r_owner;
    assign busy     = r_busy;
    assign hold_err = r_hold_err;

endmodule

// File: tb/tb_gate_arbiter.sv
// Scoreboard bench for gate_arbiter: expected {owner,result} queued at request time,
// popped on every valid pulse; directed checks on grant timing, hold and reset.
module tb_gate_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [7:0] opcode;
    logic [3:0] opnd_a, opnd_b, opnd_s;
    logic [3:0] gnt;
    logic       result, valid, busy, hold_err;
    logic [1:0] owner;

    int n_cmp = 0;
    int n_bad = 0;
    logic [2:0] sb_q[$];
    logic       mon_en = 1'b0;

    gate_arbiter #(.HOLD_MAX(15)) dut (
        .clk(clk), .rst(rst), .req(req), .opcode(opcode),
        .opnd_a(opnd_a), .opnd_b(opnd_b), .opnd_s(opnd_s),
        .gnt(gnt), .result(result), .valid(valid), .owner(owner),
        .busy(busy), .hold_err(hold_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gnt != 4'b0) return;
        end
        check_eq("gnt_timeout", 8'd0, 8'd1);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid === 1'b1) return;
        end
        check_eq("valid_timeout", 8'd0, 8'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy === 1'b0) return;
        end
        check_eq("idle_timeout", 8'd0, 8'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_gnt"},  8'(gnt), 8'h0);
        check_eq({tag, "_val"},  8'(valid), 8'h0);
        check_eq({tag, "_res"},  8'(result), 8'h0);
        check_eq({tag, "_own"},  8'(owner), 8'h0);
        check_eq({tag, "_busy"}, 8'(busy), 8'h0);
        check_eq({tag, "_herr"}, 8'(hold_err), 8'h0);
    endtask

    // Scoreboard side: every valid must match the oldest queued expectation; grant stays one-hot.
    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("gnt_onehot", 8'($countones(gnt) <= 1), 8'd1);
            if (valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check_eq("extra_valid", 8'd1, 8'd0);
                end else begin
                    logic [2:0] e;
                    e = sb_q.pop_front();
                    check_eq("sb_owner",  8'(owner),  8'(e[2:1]));
                    check_eq("sb_result", 8'(result), 8'(e[0]));
                end
            end
        end
    end

    initial begin
        rst = 1'b1; req = '0; opcode = '0;
        opnd_a = '0; opnd_b = '0; opnd_s = '0;
        tick(); tick();
        check_reset_vals("rst0");
        mon_en = 1'b1;

        // Basic OR on requester 0, exact cycle timing.
        rst = 1'b0; req = 4'b0001; opcode = 8'h01; opnd_a = 4'b0000; opnd_b = 4'b0001;
        sb_q.push_back({2'd0, 1'b1});
        tick();
        check_eq("t1_gnt_c1", 8'(gnt), 8'h01);
        check_eq("t1_busy",   8'(busy), 8'h01);
        tick();
        check_eq("t1_noval_c2", 8'(valid), 8'h00);
        tick();
        check_eq("t1_val_c3", 8'(valid), 8'h01);
        check_eq("t1_res_c3", 8'(result), 8'h01);
        tick(); tick();
        req = 4'b0000;
        check_eq("t1_gnt_held", 8'(gnt), 8'h01);
        tick();
        check_eq("t1_gnt_rel", 8'(gnt), 8'h00);
        check_eq("t1_idle", 8'(busy), 8'h00);
        tick();
        check_eq("t1_res_hold", 8'(result), 8'h01);
        check_eq("t1_val_low", 8'(valid), 8'h00);

        // All four requesting: round-robin 0,1,2,3,0.
        rst = 1'b1; tick(); rst = 1'b0;
        opcode = 8'hFF; opnd_a = 4'b0101; opnd_b = '0; opnd_s = '0;
        for (int k = 0; k < 5; k++) sb_q.push_back({2'(k % 4), ((k % 2) == 0)});
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int w;
            w = k % 4;
            wait_gnt();
            check_eq("t2_order", 8'(gnt), 8'(4'b0001 << w));
            wait_valid();
            tick();
            if (k == 4) req = 4'b0000;
            else        req[w] = 1'b0;
            tick();
            check_eq("t2_rel", 8'(gnt), 8'h00);
            if (k < 4) req[w] = 1'b1;
        end
        wait_idle();

        // MUX on requester 2; operand changes during EXEC must be ignored.
        opcode = 8'h20; opnd_s = 4'b0100; opnd_a = 4'b0000; opnd_b = 4'b0100;
        sb_q.push_back({2'd2, 1'b1});
        req = 4'b0100;
        wait_gnt();
        check_eq("t3_gnt", 8'(gnt), 8'h04);
        tick();
        opnd_s = 4'b0000; opnd_b = 4'b0000;
        wait_valid();
        check_eq("t3_mux_s1", 8'(result), 8'h01);
        tick(); req = 4'b0000;
        wait_idle();
        opnd_s = 4'b0000; opnd_b = 4'b0100;
        sb_q.push_back({2'd2, 1'b0});
        req = 4'b0100;
        wait_gnt();
        tick();
        opnd_s = 4'b0100;
        wait_valid();
        check_eq("t3_mux_s0", 8'(result), 8'h00);
        tick(); req = 4'b0000;
        wait_idle();

        // Requester 1 overstays: forced release 15 cycles after valid, then requester 2.
        opcode = 8'h30; opnd_a = 4'b0100; opnd_b = '0; opnd_s = '0;
        sb_q.push_back({2'd1, 1'b1});
        sb_q.push_back({2'd2, 1'b1});
        req = 4'b0110;
        wait_gnt();
        check_eq("t4_gnt1", 8'(gnt), 8'h02);
        wait_valid();
        for (int i = 0; i < 14; i++) tick();
        check_eq("t4_gnt_v14", 8'(gnt), 8'h02);
        check_eq("t4_herr_v14", 8'(hold_err), 8'h00);
        tick();
        check_eq("t4_forced", 8'(gnt), 8'h00);
        check_eq("t4_herr", 8'(hold_err), 8'h01);
        check_eq("t4_idle", 8'(busy), 8'h00);
        tick();
        check_eq("t4_gnt2", 8'(gnt), 8'h04);
        wait_valid();
        tick(); tick();
        req = 4'b0000;
        wait_idle();
        check_eq("t4_herr_sticky", 8'(hold_err), 8'h01);

        // One-cycle pulse on requester 3 aborts in GRANT; pointer wraps to 0.
        opcode = 8'h03; opnd_a = 4'b0001;
        req = 4'b1000;
        tick();
        req = 4'b0000;
        check_eq("t5_gnt3", 8'(gnt), 8'h08);
        tick();
        check_eq("t5_abort_gnt", 8'(gnt), 8'h00);
        check_eq("t5_abort_busy", 8'(busy), 8'h00);
        tick();
        check_eq("t5_noval", 8'(valid), 8'h00);
        sb_q.push_back({2'd0, 1'b1});
        req = 4'b1001;
        wait_gnt();
        check_eq("t5_ptr0", 8'(gnt), 8'h01);
        wait_valid();
        tick(); req = 4'b0000;
        wait_idle();

        // Reset mid-RELEASE, then a fresh request is served normally.
        opcode = 8'h0C; opnd_a = 4'b0010;
        sb_q.push_back({2'd1, 1'b1});
        req = 4'b0010;
        wait_gnt();
        wait_valid();
        tick();
        rst = 1'b1; req = 4'b0000;
        tick();
        check_reset_vals("t6_rst");
        rst = 1'b0; opcode = 8'h30; opnd_a = 4'b0100;
        sb_q.push_back({2'd2, 1'b1});
        req = 4'b0100;
        tick();
        check_eq("t6_gnt", 8'(gnt), 8'h04);
        wait_valid();
        tick(); req = 4'b0000;
        wait_idle();

        tick();
        check_eq("sb_empty", 8'(sb_q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gate_arbiter.md
GATE_ARBITER -- requirements
Module: gate_arbiter

Interface
REQ-001 SHALL: parameter HOLD_MAX, default 15, meaning the maximum number of cycles a requester may keep req high after its result is issued (range 1..15).
REQ-002 SHALL: clk  input  1  the only clock; all logic is on the rising edge.
REQ-003 SHALL: rst  input  1  reset; reset is synchronous and active-high.
REQ-004 SHALL: req  input  4  request line per requester 0..3.
REQ-005 SHALL: opcode  input  8  2 bits per requester (requester i uses bits [2i+1:2i]); 00 = NOT a, 01 = OR a,b, 10 = MUX (s ? b : a), 11 = pass a.
REQ-006 SHALL: opnd_a, opnd_b, opnd_s  input  4 each  operand bit per requester (bit i belongs to requester i).
REQ-007 SHALL: gnt  output  4  one-hot grant, or all zero.
REQ-008 SHALL: result  output  1  registered output of the shared logic unit.
REQ-009 SHALL: valid  output  1  one-cycle pulse marking result as new.
REQ-010 SHALL: owner  output  2  index of the requester that the current or most recent result belongs to.
REQ-011 SHALL: busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 SHALL: hold_err  output  1  sticky flag set on a forced release; cleared only by reset.

Function
REQ-013 SHALL: FSM states are IDLE, GRANT, EXEC, RELEASE.
REQ-014 SHALL: IDLE -> GRANT when any req bit is high; the winner is the first high req found searching from the round-robin pointer ptr upward, mod 4; gnt[winner] rises on entry to GRANT.
REQ-015 SHALL: GRANT lasts 1 cycle; it latches opcode/operands of the winner; if req[winner] is low in this cycle, the request is aborted: gnt -> 0, no valid, ptr = winner+1, FSM -> IDLE.
REQ-016 SHALL: EXEC lasts 1 cycle; it computes the latched op; on the next edge result is updated, valid pulses high for exactly 1 cycle, owner = winner, and the FSM goes to RELEASE.
REQ-017 SHALL: in RELEASE, gnt stays asserted while req[winner] is high; the first cycle req[winner] is low, gnt -> 0, ptr = winner+1 (mod 4), and the FSM goes to IDLE.
REQ-018 SHALL: a hold counter (4 bits) increments each RELEASE cycle while req[winner] is high; when the count reaches HOLD_MAX, gnt is forced to 0, hold_err is set, ptr advances, and the FSM goes to IDLE.
REQ-019 SHALL: req changes from non-winners during GRANT/EXEC/RELEASE have no effect; opcode/operand changes after the GRANT latch do not affect result.
REQ-020 SHALL: there is at least one IDLE cycle between successive grants, giving a minimum of 4 cycles per transaction from req to the next gnt.
REQ-021 SHALL: result and owner hold their value between valid pulses.
REQ-022 SHALL: ptr wraps from 3 to 0; when all four request simultaneously, grants are issued in the order ptr, ptr+1, ptr+2, ptr+3.

Reset
REQ-023 SHALL: while rst is high at an edge: FSM = IDLE, gnt = 0, result = 0, valid = 0, owner = 0, busy = 0, hold_err = 0, ptr = 0, hold counter = 0.
REQ-024 SHALL: rst asserted in any state (including mid-RELEASE) aborts the transaction with no valid pulse; arbitration restarts from ptr = 0.

Verification
REQ-025 SHALL: after reset, req=0001, opcode[1:0]=01, a0=0, b0=1, req dropped 2 cycles after valid -> gnt=0001 at cycle 1, valid with result=1 and owner=0 at cycle 3, gnt=0 the cycle after req falls.
REQ-026 SHALL: req=1111 held, each requester dropping req 1 cycle after its valid -> grant order 0,1,2,3, then 0 again; never two gnt bits high.
REQ-027 SHALL: requester 2 with opcode 10 and s=1, a=0, b=1, then s=0 -> result=1, then result=0; operand change during EXEC -> no effect on result.
REQ-028 SHALL: requester 1 holds req for 20 cycles after valid, HOLD_MAX=15 -> forced release 15 cycles after valid, hold_err=1, and requester 2 is granted next if requesting.
REQ-029 SHALL: req[3] pulsed for 1 cycle only -> GRANT aborts, no valid, ptr = 0.
REQ-030 SHALL: rst asserted during RELEASE -> next cycle all outputs are at reset values, and a new req=0100 is granted normally.
